// File: rtl/rseq_ctrl_if.sv
// rseq_ctrl_if
// Groups the request, ROM and uop-pipeline signals of the microsequence
// ROM sequencer.
//   master : the sequencer (rseq_ctrl). It takes the requests, stall and
//            ROM data, and drives the ROM address, uop slot, vec, busy and acks.
//   slave  : the environment around it (front end, ROM, downstream stage).
interface rseq_ctrl_if;
  logic         exc_req;
  logic [7:0]   exc_vec;
  logic         int_req;
  logic [7:0]   int_vec;
  logic         iret_req;
  logic         stall;
  logic [127:0] rseq_data;
  logic [2:0]   rseq_addr;
  logic         rseq_oe;
  logic         uop_v;
  logic [127:0] uop_data;
  logic [7:0]   vec;
  logic         busy;
  logic         exc_ack;
  logic         int_ack;
  logic         iret_ack;

  modport master (
    input  exc_req, exc_vec, int_req, int_vec, iret_req, stall, rseq_data,
    output rseq_addr, rseq_oe, uop_v, uop_data, vec, busy,
           exc_ack, int_ack, iret_ack
  );

  modport slave (
    output exc_req, exc_vec, int_req, int_vec, iret_req, stall, rseq_data,
    input  rseq_addr, rseq_oe, uop_v, uop_data, vec, busy,
           exc_ack, int_ack, iret_ack
  );
endinterface

// File: rtl/rseq_ctrl.sv
// rseq_ctrl
// Reader/sequencer for the 8 x 128-bit interrupt/exception/iret
// microsequence ROM. It arbitrates the three requests (exc > int > iret),
// jumps to the winner's entry point and then steps the ROM address once per
// unstalled cycle. Each word is registered into a single valid/stall slot
// for the downstream stage. While a sequence runs, busy stalls the front end.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : rseq_ctrl_if.master
//          in  : exc_req/exc_vec, int_req/int_vec, iret_req, stall, rseq_data
//          out : rseq_addr, rseq_oe, uop_v, uop_data, vec, busy,
//                exc_ack, int_ack, iret_ack
module rseq_ctrl #(
  parameter logic [2:0] EXC_BASE  = 3'd0,
  parameter logic [2:0] INT_BASE  = 3'd3,
  parameter logic [2:0] IRET_BASE = 3'd6,
  parameter int         END_BIT   = 127
) (
  input  logic         clk,
  input  logic         rst,
  rseq_ctrl_if.master  bus
);

  typedef enum logic {IDLE, SEQ} state_t;
  typedef enum logic [1:0] {K_EXC = 2'd0, K_INT = 2'd1, K_IRET = 2'd2} kind_t;

  state_t        r_state;
  kind_t         r_kind;
  logic [2:0]    r_addr;
  logic          r_uop_v;
  logic [127:0]  r_uop_data;
  logic [7:0]    r_vec;
  logic          r_busy;
  logic          r_exc_ack;
  logic          r_int_ack;
  logic          r_iret_ack;

  // A sequence ends on its flagged word, or at the top of the ROM. There is
  // no wrap back to 0 inside a sequence.
  logic w_last;
  // Only an exception interrupts a running sequence. An exception that is
  // already running cannot be nested.
  logic w_abort;

  assign w_last  = bus.rseq_data[END_BIT] || (r_addr == 3'd7);
  assign w_abort = bus.exc_req && (r_kind != K_EXC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_kind     <= K_EXC;
      r_addr     <= 3'd0;
      r_uop_v    <= 1'b0;
      r_uop_data <= '0;
      r_vec      <= 8'd0;
      r_busy     <= 1'b0;
      r_exc_ack  <= 1'b0;
      r_int_ack  <= 1'b0;
      r_iret_ack <= 1'b0;
    end else begin
      // Acks are single-cycle pulses.
      r_exc_ack  <= 1'b0;
      r_int_ack  <= 1'b0;
      r_iret_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          // The last word of the previous sequence stays in the slot until
          // the downstream stage takes it.
          if (!bus.stall) r_uop_v <= 1'b0;
          if (bus.exc_req) begin
            r_state   <= SEQ;
            r_busy    <= 1'b1;
            r_addr    <= EXC_BASE;
            r_kind    <= K_EXC;
            r_vec     <= bus.exc_vec;
            r_exc_ack <= 1'b1;
          end else if (bus.int_req) begin
            r_state   <= SEQ;
            r_busy    <= 1'b1;
            r_addr    <= INT_BASE;
            r_kind    <= K_INT;
            r_vec     <= bus.int_vec;
            r_int_ack <= 1'b1;
          end else if (bus.iret_req) begin
            r_state    <= SEQ;
            r_busy     <= 1'b1;
            r_addr     <= IRET_BASE;
            r_kind     <= K_IRET;
            r_vec      <= 8'd0;
            r_iret_ack <= 1'b1;
          end
        end
        SEQ: begin
          if (w_abort) begin
            // Restart at the exception entry. The word in the slot belongs
            // to the discarded sequence, so it is dropped even under stall.
            r_addr    <= EXC_BASE;
            r_kind    <= K_EXC;
            r_vec     <= bus.exc_vec;
            r_exc_ack <= 1'b1;
            r_uop_v   <= 1'b0;
          end else if (!bus.stall) begin
            r_uop_data <= bus.rseq_data;
            r_uop_v    <= 1'b1;
            if (w_last) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_addr  <= 3'd0;
            end else begin
              r_addr <= r_addr + 3'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rseq_addr = r_addr;
  assign bus.rseq_oe   = (r_state == SEQ);
  assign bus.uop_v     = r_uop_v;
  assign bus.uop_data  = r_uop_data;
  assign bus.vec       = r_vec;
  assign bus.busy      = r_busy;
  assign bus.exc_ack   = r_exc_ack;
  assign bus.int_ack   = r_int_ack;
  assign bus.iret_ack  = r_iret_ack;

endmodule
